// File: rtl/board_text_pkg.sv
// board_text_pkg: shared ASCII constants, FSM state type and frame-length helper
// for board_text_serializer and its bin_to_bcd converter.
package board_text_pkg;
  localparam logic [7:0] SPACE = 8'h20;
  localparam logic [7:0] DOT   = 8'h2e;
  localparam logic [7:0] BAR   = 8'h7c;
  localparam logic [7:0] HASH  = 8'h23;
  localparam logic [7:0] DASH  = 8'h2d;
  localparam logic [7:0] CR    = 8'h0d;
  localparam logic [7:0] LF    = 8'h0a;
  localparam logic [7:0] ZERO  = 8'h30;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CONV, S_EMIT, S_FIN} state_t;
  // i-th character of the "SCORE:" label
  function automatic logic [7:0] score_ch(input int i);
    return i == 0 ? 8'h53 : i == 1 ? 8'h43 : i == 2 ? 8'h4f : i == 3 ? 8'h52 : i == 4 ? 8'h45 : 8'h3a;
  endfunction
  // total frame length in chars, n = printed score digits
  function automatic int frame_len(input int rows, input int cols, input int digits, input int n, input bit border);
    return rows * (cols * digits + cols + 1) + 6 + n + 2 + (border ? 2 * (cols * digits + cols + 1) : 0);
  endfunction
endpackage

// File: rtl/board_text_serializer_bin_to_bcd.sv
// bin_to_bcd: iterative double-dabble binary to BCD converter.
//  clk, rst    clock, async active-high reset
//  start       load din and begin; conversion takes nbits cycles
//  din, nbits  value (low nbits significant) and its bit count
//  ready       idle, bcd/ovf hold the last result
//  bcd         DIGITS BCD nibbles, digit 0 least significant
//  ovf         value did not fit in DIGITS decimal digits
module bin_to_bcd #(
  parameter int W      = 21,
  parameter int DIGITS = 7
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [W-1:0]            din,
  input  logic [$clog2(W+1)-1:0]  nbits,
  output logic                    ready,
  output logic [4*DIGITS-1:0]     bcd,
  output logic                    ovf
);
  localparam int NW = $clog2(W + 1);
  logic [W-1:0] sh_q, sh_d;
  logic [NW-1:0] cnt_q, cnt_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d, adj;
  logic ovf_q, ovf_d, run;
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < DIGITS; i++)
      adj[4*i +: 4] = bcd_q[4*i +: 4] > 4'd4 ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
    run = cnt_q != '0;
    // left-align the value so its MSB is the first bit shifted in
    sh_d = start ? din << (NW'(W) - nbits) : run ? sh_q << 1 : sh_q;
    cnt_d = start ? nbits : run ? cnt_q - 1'b1 : cnt_q;
    bcd_d = start ? '0 : run ? {adj[4*DIGITS-2:0], sh_q[W-1]} : bcd_q;
    // a bit carried out of the top digit means the value reached 10^DIGITS
    ovf_d = start ? 1'b0 : run ? ovf_q | adj[4*DIGITS-1] : ovf_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sh_q <= '0;
      cnt_q <= '0;
      bcd_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      sh_q <= sh_d;
      cnt_q <= cnt_d;
      bcd_q <= bcd_d;
      ovf_q <= ovf_d;
    end
  assign ready = !run;
  assign bcd = bcd_q;
  assign ovf = ovf_q;
endmodule

// File: rtl/board_text_serializer.sv
// board_text_serializer: captures a ROWS x COLS tile board plus score on start and
// streams it as ASCII text, one char per char_valid && print_nxt handshake.
//  clk, rst          clock, async active-high reset
//  board, score      tile i at board[i*TILE_W +: TILE_W] (row-major), unsigned score
//  start             begin a frame, sampled only when idle
//  print_nxt         consumer takes char_out this cycle
//  char_out          ASCII char, stable while char_valid
//  char_valid, busy  char present / frame in progress
//  done              one-cycle pulse after the last char is taken
// Optional: BOARD_TEXT_BORDER_EN adds a dashed border line before and after the grid.
module board_text_serializer
  import board_text_pkg::*;
#(
  parameter int ROWS         = 4,
  parameter int COLS         = 4,
  parameter int TILE_W       = 20,
  parameter int DIGITS       = 7,
  parameter int SCORE_W      = 21,
  parameter int SCORE_DIGITS = 7
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [ROWS*COLS*TILE_W-1:0] board,
  input  logic [SCORE_W-1:0]          score,
  input  logic                        start,
  input  logic                        print_nxt,
  output logic [7:0]                  char_out,
  output logic                        char_valid,
  output logic                        busy,
  output logic                        done
);
  localparam int NT = ROWS * COLS;
  localparam int DM = DIGITS > SCORE_DIGITS ? DIGITS : SCORE_DIGITS;
  localparam int CW = TILE_W > SCORE_W ? TILE_W : SCORE_W;
  localparam int NW = $clog2(CW + 1);
  localparam int IW = $clog2(NT + 1);
  localparam int BL = COLS * DIGITS + COLS - 1;
`ifdef BOARD_TEXT_BORDER_EN
  localparam int PB = BL + 2;
`else
  localparam int PB = 0;
`endif
  state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [15:0] ci_q, ci_d;
  logic [NT*TILE_W-1:0] board_q, board_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic cs_q, cs_d, cv_q, cv_d, busy_q, busy_d, done_q, done_d;
  logic [7:0] char_q, char_d, ch_n;
  logic rdy, ovf, is_sc, zero, lastc, hi, vovf;
  logic [4*DM-1:0] bcd;
  logic [DM:0] sig;
  logic [CW-1:0] cur;
  int nd, nsd, nd2, pre, len, n, f, j;
  bin_to_bcd #(.W(CW), .DIGITS(DM)) u_bcd (
    .clk(clk),
    .rst(rst),
    .start(cs_q),
    .din(cur),
    .nbits(is_sc ? NW'(SCORE_W) : NW'(TILE_W)),
    .ready(rdy),
    .bcd(bcd),
    .ovf(ovf)
  );
  // item idx_q (tile, or score when idx_q == NT) and the char at index n of its text
  always_comb begin
    is_sc = idx_q == IW'(NT);
    cur = is_sc ? CW'(score_q) : CW'(board_q[idx_q*TILE_W +: TILE_W]);
    zero = cur == '0;
    lastc = int'(idx_q) % COLS == COLS - 1;
    nd = is_sc ? SCORE_DIGITS : DIGITS;
    sig = '0;
    hi = 1'b0;
    nsd = 1;
    // sig[k]: digit k or a higher one is nonzero, i.e. not a leading zero
    for (int k = DM - 1; k >= 0; k--) sig[k] = sig[k+1] | (|bcd[4*k +: 4]);
    for (int k = 0; k < DM; k++) begin
      nsd = sig[k] ? k + 1 : nsd;
      hi = hi | (k >= nd && |bcd[4*k +: 4]);
    end
    vovf = ovf | hi;
    nd2 = vovf ? SCORE_DIGITS : nsd;
    pre = (idx_q == '0 || is_sc) ? PB : 0;
    len = is_sc ? pre + 6 + nd2 + 2 : pre + DIGITS + (lastc ? 2 : 1);
    n = state_q == S_CONV ? 0 : int'(ci_q) + 1;
    f = n - pre;
    j = f - 6;
    if (n < pre) ch_n = n < BL ? DASH : n == BL ? CR : LF;
    else if (is_sc)
      ch_n = f < 6 ? score_ch(f) : j < nd2 ? (vovf ? HASH : ZERO + 8'(bcd[4*(nd2-1-j) +: 4])) : j == nd2 ? CR : LF;
    else
      ch_n = f < DIGITS ? (vovf ? HASH : zero ? (f == DIGITS - 1 ? DOT : SPACE) :
             sig[DIGITS-1-f] ? ZERO + 8'(bcd[4*(DIGITS-1-f) +: 4]) : SPACE) :
             f == DIGITS ? (lastc ? CR : BAR) : LF;
  end
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    ci_d = ci_q;
    board_d = board_q;
    score_d = score_q;
    cs_d = 1'b0;
    char_d = char_q;
    cv_d = cv_q;
    done_d = 1'b0;
    case (state_q)
      S_IDLE: state_d = start ? S_LOAD : S_IDLE;
      S_LOAD: begin
        board_d = board;
        score_d = score;
        idx_d = '0;
        cs_d = 1'b1;
        state_d = S_CONV;
      end
      // cs_q marks the converter's load cycle, when ready still shows the old result
      S_CONV: if (!cs_q && rdy) begin
        state_d = S_EMIT;
        ci_d = '0;
        cv_d = 1'b1;
        char_d = ch_n;
      end
      S_EMIT: if (cv_q && print_nxt) begin
        if (int'(ci_q) == len - 1) begin
          cv_d = 1'b0;
          state_d = is_sc ? S_FIN : S_CONV;
          done_d = is_sc;
          cs_d = !is_sc;
          idx_d = is_sc ? idx_q : idx_q + 1'b1;
        end else begin
          ci_d = ci_q + 1'b1;
          char_d = ch_n;
        end
      end
      S_FIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = state_d != S_IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= S_IDLE;
      idx_q <= '0;
      ci_q <= '0;
      board_q <= '0;
      score_q <= '0;
      cs_q <= 1'b0;
      char_q <= 8'h00;
      cv_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      ci_q <= ci_d;
      board_q <= board_d;
      score_q <= score_d;
      cs_q <= cs_d;
      char_q <= char_d;
      cv_q <= cv_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  assign char_out = char_q;
  assign char_valid = cv_q;
  assign busy = busy_q;
  assign done = done_q;
endmodule
